// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for the execute stage.
// Takes one load/store at a time, screens out illegal and misaligned
// requests, drives the memory port, waits out the read latency, then
// aligns and sign/zero-extends the returned lane into a 32-bit result.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_rw,
    output logic        mem_sign_ext,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Final value of the load wait counter: ACCESS lasts MEM_LATENCY+1 cycles.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY);

    state_t      state_reg;
    logic        pend_reg;      // request latched in IDLE, decoded next cycle
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  cnt_reg;

    logic        illegal;
    logic        misaligned;
    logic [2:0]  acc_width;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Decode the latched request: fault flags, access width and store lane replication.
    always_comb begin
        illegal    = store_reg ? (funct3_reg >= 3'b011)
                               : ((funct3_reg == 3'b011) || (funct3_reg[2:1] == 2'b11));
        misaligned = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                     ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
        case (funct3_reg[1:0])
            2'b00: begin
                acc_width = 3'd1;
                acc_wstrb = 4'b0001 << addr_reg[1:0];
                acc_wdata = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                acc_width = 3'd2;
                acc_wstrb = 4'b0011 << addr_reg[1:0];
                acc_wdata = {2{wdata_reg[15:0]}};
            end
            default: begin
                acc_width = 3'd4;
                acc_wstrb = 4'b1111;
                acc_wdata = wdata_reg;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits.
    always_comb begin
        case (addr_reg[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Request/access/response FSM; every output is a register so reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pend_reg        <= 1'b0;
            store_reg       <= 1'b0;
            funct3_reg      <= 3'b000;
            addr_reg        <= 32'h0;
            wdata_reg       <= 32'h0;
            cnt_reg         <= 4'h0;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            mem_rw          <= 1'b0;
            mem_sign_ext    <= 1'b0;
            mem_width       <= 3'd0;
            mem_addr        <= 32'h0;
            mem_wdata       <= 32'h0;
            mem_wstrb       <= 4'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_reg) begin
                        pend_reg <= 1'b0;
                        if (illegal || misaligned) begin
                            // Faults go straight to the response; memory never sees them.
                            state_reg       <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= 32'h0;
                            resp_illegal    <= illegal;
                            resp_misaligned <= misaligned && !illegal;
                        end else begin
                            state_reg    <= ACCESS;
                            cnt_reg      <= 4'h0;
                            mem_rw       <= store_reg;
                            mem_sign_ext <= !store_reg && !funct3_reg[2];
                            mem_width    <= acc_width;
                            mem_addr     <= addr_reg;
                            mem_wstrb    <= store_reg ? acc_wstrb : 4'h0;
                            if (store_reg) begin
                                mem_wdata <= acc_wdata;
                            end
                        end
                    end else if (req_ready && req_valid) begin
                        req_ready  <= 1'b0;
                        pend_reg   <= 1'b1;
                        store_reg  <= req_store;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (store_reg || (cnt_reg == LAST_CNT)) begin
                        state_reg       <= RESP;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= store_reg ? 32'h0 : load_data;
                        resp_illegal    <= 1'b0;
                        resp_misaligned <= 1'b0;
                        mem_rw          <= 1'b0;
                        mem_width       <= 3'd0;
                        mem_wstrb       <= 4'h0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'h1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg       <= IDLE;
                        resp_valid      <= 1'b0;
                        resp_illegal    <= 1'b0;
                        resp_misaligned <= 1'b0;
                        req_ready       <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
